upc_scan_ctrl: RTL and testbench

Sequencing controller for the item-name display path. Owns the 3-bit `upc` input of the item-name decoder and decides when the decoded name is shown on HEX5..HEX0, when an error indication is shown, and when the display auto-browses the catalogue. Takes a raw pushbutton scan request and switch-set UPC, and keeps a saturating count of accepted scans.

---
 rtl/upc_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_upc_scan_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/upc_scan_ctrl.sv
// Scan/browse sequencer for the item-name display: synchronises raw inputs,
// validates scanned UPCs, times SHOW/ERR holds and steps the auto-browse catalogue.
module upc_scan_ctrl #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] sw_upc,
  input  logic       key_scan_n,
  input  logic       browse,
  output logic [2:0] upc_out,
  output logic       show,
  output logic       err,
  output logic [7:0] scan_count,
  output logic       busy
);

  localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ERR, BROWSE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    upc_d;
  logic [7:0]    cnt_d;
  logic [2:0]    sw_s1, sw_s2;
  logic          key_s1, key_s2, key_s3;
  logic          brw_s1, brw_s2;
  logic          scan;

  function automatic logic upc_valid(input logic [2:0] c);
    return !(c == 3'b010 || c == 3'b111);
  endfunction

  // Catalogue order used by auto-browse; skips the two invalid codes.
  function automatic logic [2:0] upc_next(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b110;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  assign scan = key_s3 & ~key_s2;

  always_comb begin
    state_d = state_q;
    upc_d   = upc_out;
    cnt_d   = scan_count;
    timer_d = timer_q;
    if (scan) begin
      timer_d = '0;
      if (upc_valid(sw_s2)) begin
        state_d = SHOW;
        upc_d   = sw_s2;
        cnt_d   = (scan_count == 8'hFF) ? scan_count : scan_count + 8'd1;
      end else begin
        state_d = ERR;
      end
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (brw_s2) begin
            state_d = BROWSE;
            upc_d   = 3'b000;
          end
        end
        SHOW, ERR: begin
          if (timer_q == LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        BROWSE: begin
          if (!brw_s2) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == LAST) begin
            upc_d   = upc_next(upc_out);
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Display flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      upc_out    <= 3'b000;
      scan_count <= 8'd0;
      show       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      sw_s1      <= 3'b000;
      sw_s2      <= 3'b000;
      key_s1     <= 1'b1;
      key_s2     <= 1'b1;
      key_s3     <= 1'b1;
      brw_s1     <= 1'b0;
      brw_s2     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      upc_out    <= upc_d;
      scan_count <= cnt_d;
      show       <= (state_d == SHOW) || (state_d == BROWSE);
      err        <= (state_d == ERR);
      busy       <= (state_d != IDLE);
      sw_s1      <= sw_upc;
      sw_s2      <= sw_s1;
      key_s1     <= key_scan_n;
      key_s2     <= key_s1;
      key_s3     <= key_s2;
      brw_s1     <= browse;
      brw_s2     <= brw_s1;
    end
  end

endmodule

// File: tb/tb_upc_scan_ctrl.sv
// Directed bench for upc_scan_ctrl with HOLD_CYCLES=4: per-cycle vector table
// for basic scans plus hand-written browse, priority, retrigger and reset sequences.
module tb_upc_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic [2:0] sw_upc;
  logic       key_scan_n;
  logic       browse;
  logic [2:0] upc_out;
  logic       show;
  logic       err;
  logic [7:0] scan_count;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  upc_scan_ctrl #(.HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_upc     (sw_upc),
    .key_scan_n (key_scan_n),
    .browse     (browse),
    .upc_out    (upc_out),
    .show       (show),
    .err        (err),
    .scan_count (scan_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sw;
    logic       key;
    logic       brw;
    logic [2:0] upc;
    logic       show;
    logic       err;
    logic [7:0] cnt;
    logic       busy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic [2:0] sw, input logic key, input logic brw,
                              input logic [2:0] upc, input logic sh, input logic er,
                              input logic [7:0] cnt, input logic bz);
    vec_t v;
    v.sw = sw; v.key = key; v.brw = brw; v.upc = upc;
    v.show = sh; v.err = er; v.cnt = cnt; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string name, input logic [2:0] u, input logic sh,
                         input logic er, input logic [7:0] c, input logic bz);
    chk({name, ".upc"},   32'(upc_out),    32'(u));
    chk({name, ".show"},  32'(show),       32'(sh));
    chk({name, ".err"},   32'(err),        32'(er));
    chk({name, ".count"}, 32'(scan_count), 32'(c));
    chk({name, ".busy"},  32'(busy),       32'(bz));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press/release; the scan lands on the third edge after the press.
  task automatic do_scan();
    key_scan_n = 1'b0; tick(); tick();
    key_scan_n = 1'b1; tick(); tick();
  endtask

  logic [2:0] codes[7];

  initial begin
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b011; codes[3] = 3'b100;
    codes[4] = 3'b101; codes[5] = 3'b110; codes[6] = 3'b000;

    // Valid scan of 011 then invalid scan of 111, one row per clock.
    tbl[0]  = mk(3'd3, 1, 0, 3'd0, 0, 0, 8'd0, 0);
    tbl[1]  = mk(3'd3, 1, 0, 3'd0, 0, 0, 8'd0, 0);
    tbl[2]  = mk(3'd3, 0, 0, 3'd0, 0, 0, 8'd0, 0);
    tbl[3]  = mk(3'd3, 0, 0, 3'd0, 0, 0, 8'd0, 0);
    tbl[4]  = mk(3'd3, 0, 0, 3'd3, 1, 0, 8'd1, 1);
    tbl[5]  = mk(3'd3, 0, 0, 3'd3, 1, 0, 8'd1, 1);
    tbl[6]  = mk(3'd3, 0, 0, 3'd3, 1, 0, 8'd1, 1);
    tbl[7]  = mk(3'd3, 0, 0, 3'd3, 1, 0, 8'd1, 1);
    tbl[8]  = mk(3'd3, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[9]  = mk(3'd3, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[10] = mk(3'd3, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[11] = mk(3'd7, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[12] = mk(3'd7, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[13] = mk(3'd7, 0, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[14] = mk(3'd7, 0, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[15] = mk(3'd7, 0, 0, 3'd3, 0, 1, 8'd1, 1);
    tbl[16] = mk(3'd7, 0, 0, 3'd3, 0, 1, 8'd1, 1);
    tbl[17] = mk(3'd7, 0, 0, 3'd3, 0, 1, 8'd1, 1);
    tbl[18] = mk(3'd7, 0, 0, 3'd3, 0, 1, 8'd1, 1);
    tbl[19] = mk(3'd7, 1, 0, 3'd3, 0, 0, 8'd1, 0);
    tbl[20] = mk(3'd7, 1, 0, 3'd3, 0, 0, 8'd1, 0);

    // Reset asserted mid-cycle takes effect before any clock edge.
    reset_n = 1'b1; sw_upc = 3'd0; key_scan_n = 1'b1; browse = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_all("reset_async", 3'd0, 0, 0, 8'd0, 0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle_after_reset", 3'd0, 0, 0, 8'd0, 0);
    end

    for (int i = 0; i < 21; i++) begin
      sw_upc = tbl[i].sw; key_scan_n = tbl[i].key; browse = tbl[i].brw;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].upc, tbl[i].show, tbl[i].err, tbl[i].cnt, tbl[i].busy);
    end
    exp_cnt = 1;

    // Auto-browse through the whole catalogue, then drop the request.
    browse = 1'b1;
    tick(); chk("browse_sync0.busy", 32'(busy), 32'd0);
    tick(); chk("browse_sync1.busy", 32'(busy), 32'd0);
    for (int c = 0; c < 7; c++)
      for (int k = 0; k < 4; k++) begin
        tick();
        chk_all($sformatf("browse_c%0d_k%0d", c, k), codes[c], 1, 0, 8'(exp_cnt), 1);
      end
    browse = 1'b0;
    tick(); chk_all("browse_drop0", 3'd1, 1, 0, 8'(exp_cnt), 1);
    tick(); chk_all("browse_drop1", 3'd1, 1, 0, 8'(exp_cnt), 1);
    tick(); chk_all("browse_drop2", 3'd1, 0, 0, 8'(exp_cnt), 0);

    // Scan of 101 during browse preempts it; browse restarts at 000 after one idle cycle.
    sw_upc = 3'd5; browse = 1'b1;
    tick(); tick();
    tick(); chk_all("prio_browse", 3'd0, 1, 0, 8'(exp_cnt), 1);
    key_scan_n = 1'b0;
    tick(); tick();
    tick(); exp_cnt++;
    chk_all("prio_show0", 3'd5, 1, 0, 8'(exp_cnt), 1);
    for (int k = 1; k < 4; k++) begin
      tick(); chk_all($sformatf("prio_show%0d", k), 3'd5, 1, 0, 8'(exp_cnt), 1);
    end
    tick(); chk_all("prio_idle", 3'd5, 0, 0, 8'(exp_cnt), 0);
    tick(); chk_all("prio_rebrowse", 3'd0, 1, 0, 8'(exp_cnt), 1);
    browse = 1'b0; key_scan_n = 1'b1;
    tick(); tick();
    tick(); chk_all("prio_exit", 3'd0, 0, 0, 8'(exp_cnt), 0);

    // Second scan lands exactly on the SHOW timeout edge and restarts the hold.
    sw_upc = 3'd1;
    tick(); tick();
    key_scan_n = 1'b0;
    tick(); tick();
    key_scan_n = 1'b1; sw_upc = 3'd4;
    tick(); exp_cnt++;
    chk_all("retrig_first", 3'd1, 1, 0, 8'(exp_cnt), 1);
    tick(); chk_all("retrig_t1", 3'd1, 1, 0, 8'(exp_cnt), 1);
    key_scan_n = 1'b0;
    tick(); chk_all("retrig_t2", 3'd1, 1, 0, 8'(exp_cnt), 1);
    tick(); chk_all("retrig_t3", 3'd1, 1, 0, 8'(exp_cnt), 1);
    tick(); exp_cnt++;
    chk_all("retrig_new", 3'd4, 1, 0, 8'(exp_cnt), 1);
    for (int k = 1; k < 4; k++) begin
      tick(); chk_all($sformatf("retrig_hold%0d", k), 3'd4, 1, 0, 8'(exp_cnt), 1);
    end
    tick(); chk_all("retrig_end", 3'd4, 0, 0, 8'(exp_cnt), 0);
    key_scan_n = 1'b1;
    tick(); tick();

    // A press caught by only the first sync flop must not survive reset.
    key_scan_n = 1'b0;
    tick();
    reset_n = 1'b0;
    #1 chk_all("pend_reset", 3'd0, 0, 0, 8'd0, 0);
    key_scan_n = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); chk_all($sformatf("pend_none%0d", k), 3'd0, 0, 0, 8'd0, 0);
    end

    // Saturation at 255, then async reset in the middle of a SHOW.
    sw_upc = 3'd3;
    tick(); tick();
    for (int i = 0; i < 254; i++) do_scan();
    chk("sat_254", 32'(scan_count), 32'd254);
    do_scan();
    chk("sat_255", 32'(scan_count), 32'd255);
    do_scan();
    chk("sat_256", 32'(scan_count), 32'd255);
    chk("sat_show", 32'(show), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_all("mid_show_reset", 3'd0, 0, 0, 8'd0, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk_all("post_reset_idle", 3'd0, 0, 0, 8'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // show and err must never be asserted together.
  always @(negedge clk) begin
    if (reset_n) chk("show_err_exclusive", 32'(show & err), 32'd0);
  end

endmodule
